cmerge2_arb_sync: RTL and testbench

- Clocked 2-to-1 merge for the drive/free token handshake; the converging counterpart of the 2-way selector.
- Accepts tokens from two upstream channels and arbitrates between them, round-robin or fixed priority.
- Forwards one token at a time to a single downstream channel and routes the returning free back to the granted port.
- Drives a one-hot select so a downstream data mux can follow the grant. Sits at reconvergence points of the synchronous control fabric.

---
 rtl/cmerge2_arb_sync_pkg.sv | 19 +
 rtl/cmerge2_arb_sync_rr_arb2.sv | 41 ++++
 rtl/cmerge2_arb_sync.sv | 119 +++++++++++
 tb/tb_cmerge2_arb_sync.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmerge2_arb_sync_pkg.sv
// Shared definitions for the token-merge fabric: FSM encoding and port indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmerge2_arb_sync_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int PORT0 = 0;
   localparam int PORT1 = 1;

   // One-hot select for a single port index.
   function automatic logic [1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cmerge2_arb_sync_rr_arb2.sv
// Two-requester arbiter, round-robin or fixed priority (port 0 wins).
// Latency: grant is combinational from req; preference updates one edge after advance.
// Backpressure: none; the caller samples grant only when it is ready to issue.
module rr_arb2
   import cmerge2_arb_sync_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       done_port,
   output logic [1:0] grant
);

   // Set means port 1 is preferred when both ports request.
   logic prefer1;

   // Preference flips away from whichever port just completed.
   always_ff @(posedge clk) begin
      if (rst) begin
         prefer1 <= 1'b0;
      end else if (advance) begin
         prefer1 <= ~done_port;
      end
   end

   // Contention resolves by preference only in round-robin mode.
   always_comb begin
      grant = 2'b00;
      if (req[PORT0] && req[PORT1]) begin
         grant = port_onehot(RR_EN && prefer1);
      end else if (req[PORT0]) begin
         grant = port_onehot(1'b0);
      end else if (req[PORT1]) begin
         grant = port_onehot(1'b1);
      end
   end

endmodule

// File: rtl/cmerge2_arb_sync.sv
// 2-to-1 drive/free token merge with arbitration and free routing back to the winner.
// Latency: drive->driveNext 2 cycles; freeNext->free 1 cycle; one token in flight.
// Backpressure: tokens wait as pending flags; a repeat drive on a pending port is an error.
module cmerge2_arb_sync
   import cmerge2_arb_sync_pkg::*;
#(
   parameter bit RR_EN = 1'b1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_drive0,
   output logic             o_free0,
   input  logic             i_drive1,
   output logic             o_free1,
   output logic             o_driveNext,
   input  logic             i_freeNext,
   output logic [1:0]       o_select,
   output logic [CNT_W-1:0] o_count,
   output logic             o_err
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] pending;
   logic [1:0] drive;
   logic [1:0] grant;
   logic [1:0] clear;
   logic       done;
   logic       err_hit;
   logic       drive_next_nxt;
   logic [1:0] select_nxt;
   logic [1:0] free_nxt;

   assign drive   = {i_drive1, i_drive0};
   assign done    = (state == BUSY) && i_freeNext;
   // The granted port's flag drops on completion, but a same-edge drive re-sets it.
   assign clear   = done ? o_select : 2'b00;
   assign err_hit = (|(drive & pending & ~clear)) || (i_freeNext && (state == IDLE));

   rr_arb2 #(
      .RR_EN (RR_EN)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (pending),
      .advance   (done),
      .done_port (o_select[PORT1]),
      .grant     (grant)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave IDLE on any pending token, return on the downstream free.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|pending) state_nxt = BUSY;
         BUSY:    if (i_freeNext) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: values presented in the cycle after this edge.
   always_comb begin
      drive_next_nxt = 1'b0;
      select_nxt     = o_select;
      free_nxt       = 2'b00;
      case (state)
         IDLE: begin
            select_nxt = 2'b00;
            if (|pending) begin
               drive_next_nxt = 1'b1;
               select_nxt     = grant;
            end
         end
         BUSY: begin
            if (i_freeNext) begin
               free_nxt   = o_select;
               select_nxt = 2'b00;
            end
         end
         default: select_nxt = 2'b00;
      endcase
   end

   // Registered outputs, pending flags, completion counter and sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_driveNext <= 1'b0;
         o_select    <= 2'b00;
         o_free0     <= 1'b0;
         o_free1     <= 1'b0;
         pending     <= 2'b00;
         o_count     <= '0;
         o_err       <= 1'b0;
      end else begin
         o_driveNext <= drive_next_nxt;
         o_select    <= select_nxt;
         o_free0     <= free_nxt[PORT0];
         o_free1     <= free_nxt[PORT1];
         pending     <= (pending & ~clear) | drive;
         if (done) begin
            o_count <= o_count + CNT_W'(1);
         end
         if (err_hit) begin
            o_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmerge2_arb_sync.sv
// Scoreboard bench: two merges (round-robin and fixed priority, 4-bit counters) share a stimulus plan.
// Latency: expected grants/frees are stamped with the cycle they must appear in.
// Backpressure: a reactive downstream answers each driveNext after 0..2 cycles.
module tb_cmerge2_arb_sync;

   typedef struct {
      int port;
      int cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] drive0 = 2'b00;
   logic [1:0] drive1 = 2'b00;
   logic [1:0] freen = 2'b00;
   wire  [1:0] free0;
   wire  [1:0] free1;
   wire  [1:0] dnext;
   wire  [1:0] errv;
   wire  [1:0] sel [2];
   wire  [3:0] cnt [2];

   // Instance 0 is round-robin, instance 1 is fixed priority.
   cmerge2_arb_sync #(.RR_EN(1'b1), .CNT_W(4)) dut_rr (
      .clk(clk), .rst(rst),
      .i_drive0(drive0[0]), .o_free0(free0[0]),
      .i_drive1(drive1[0]), .o_free1(free1[0]),
      .o_driveNext(dnext[0]), .i_freeNext(freen[0]),
      .o_select(sel[0]), .o_count(cnt[0]), .o_err(errv[0])
   );

   cmerge2_arb_sync #(.RR_EN(1'b0), .CNT_W(4)) dut_fp (
      .clk(clk), .rst(rst),
      .i_drive0(drive0[1]), .o_free0(free0[1]),
      .i_drive1(drive1[1]), .o_free1(free1[1]),
      .o_driveNext(dnext[1]), .i_freeNext(freen[1]),
      .o_select(sel[1]), .o_count(cnt[1]), .o_err(errv[1])
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   // Reference model state: pending tokens, owner of the in-flight token, preference.
   bit [1:0] m_pend [2];
   bit       m_busy [2];
   int       m_own  [2];
   int       m_pref [2];
   int       m_cnt  [2];
   bit       m_err  [2];
   ev_t      qg [2][$];
   ev_t      qf [2][$];

   // Stimulus controls.
   bit auto_fn = 1'b0;
   bit rereq = 1'b0;
   int rnd_mode = 0;
   bit busy_ds [2];
   int wc [2];

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", nm, i, cyc, act, exp);
      end
   endtask

   // Model: applies the token rules at every edge and queues the pulses they imply.
   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         bit fire;
         int g;
         if (rst) begin
            mon_en    = 1'b1;
            m_pend[i] = 2'b00;
            m_busy[i] = 1'b0;
            m_own[i]  = 0;
            m_pref[i] = 0;
            m_cnt[i]  = 0;
            m_err[i]  = 1'b0;
            qg[i].delete();
            qf[i].delete();
         end else begin
            fire = m_busy[i] && freen[i];
            if (freen[i] && !m_busy[i]) m_err[i] = 1'b1;
            if (drive0[i] && m_pend[i][0] && !(fire && m_own[i] == 0)) m_err[i] = 1'b1;
            if (drive1[i] && m_pend[i][1] && !(fire && m_own[i] == 1)) m_err[i] = 1'b1;
            if (fire) begin
               qf[i].push_back('{m_own[i], cyc});
               m_pend[i][m_own[i]] = 1'b0;
               m_cnt[i]  = (m_cnt[i] + 1) % 16;
               m_pref[i] = 1 - m_own[i];
               m_busy[i] = 1'b0;
            end else if (!m_busy[i] && m_pend[i] != 2'b00) begin
               if (m_pend[i] == 2'b11) g = (i == 0) ? m_pref[i] : 0;
               else g = m_pend[i][0] ? 0 : 1;
               m_own[i]  = g;
               m_busy[i] = 1'b1;
               qg[i].push_back('{g, cyc});
            end
            if (drive0[i]) m_pend[i][0] = 1'b1;
            if (drive1[i]) m_pend[i][1] = 1'b1;
         end
      end
   end

   // Monitor: compares DUT outputs mid-cycle and pops expected pulses as they appear.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 2; i++) begin
            ev_t e;
            chk("select", i, sel[i], m_busy[i] ? (1 << m_own[i]) : 0);
            chk("count", i, cnt[i], m_cnt[i]);
            chk("err", i, errv[i], m_err[i]);
            if (dnext[i]) begin
               if (qg[i].size() == 0) begin
                  chk("unexpected_drive", i, dnext[i], 0);
               end else begin
                  e = qg[i].pop_front();
                  chk("grant_port", i, sel[i], 1 << e.port);
                  chk("grant_cycle", i, cyc, e.cyc);
               end
            end
            if (free0[i] || free1[i]) begin
               if (qf[i].size() == 0) begin
                  chk("unexpected_free", i, {free1[i], free0[i]}, 0);
               end else begin
                  e = qf[i].pop_front();
                  chk("free_port", i, {free1[i], free0[i]}, 1 << e.port);
                  chk("free_cycle", i, cyc, e.cyc);
               end
            end
            chk("grant_missing", i, (qg[i].size() > 0) && (qg[i][0].cyc <= cyc), 0);
            chk("free_missing", i, (qf[i].size() > 0) && (qf[i][0].cyc <= cyc), 0);
         end
      end
   end

   // One cycle of stimulus; values set here are sampled at the following edge.
   task automatic tick(input bit r, input bit [1:0] a0, input bit [1:0] a1, input bit [1:0] f);
      @(posedge clk);
      #1;
      rst = r;
      for (int i = 0; i < 2; i++) begin
         bit x0, x1, xf;
         x0 = a0[i];
         x1 = a1[i];
         xf = f[i];
         if (rnd_mode == 1) begin
            x0 |= ($urandom_range(0, 3) == 0) && !m_pend[i][0];
            x1 |= ($urandom_range(0, 3) == 0) && !m_pend[i][1];
         end else if (rnd_mode == 2) begin
            x0 |= ($urandom_range(0, 3) == 0);
            x1 |= ($urandom_range(0, 3) == 0);
            xf |= ($urandom_range(0, 11) == 0);
         end
         if (auto_fn && !r) begin
            if (dnext[i]) begin
               busy_ds[i] = 1'b1;
               wc[i] = $urandom_range(0, 2);
            end
            if (busy_ds[i]) begin
               if (wc[i] == 0) begin
                  xf = 1'b1;
                  busy_ds[i] = 1'b0;
               end else begin
                  wc[i]--;
               end
            end
         end
         if (r) busy_ds[i] = 1'b0;
         if (rereq && xf) begin
            x0 |= sel[i][0];
            x1 |= sel[i][1];
         end
         drive0[i] = x0;
         drive1[i] = x1;
         freen[i]  = xf;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic do_reset();
      tick(1'b1, 2'b00, 2'b00, 2'b00);
      tick(1'b0, 2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      busy_ds = '{1'b0, 1'b0};
      wc = '{0, 0};
      do_reset();

      // Single port-0 token: drive at edge 1, free at edge 4.
      tick(1'b0, 2'b11, 2'b00, 2'b00);
      idle(2);
      tick(1'b0, 2'b00, 2'b00, 2'b11);
      idle(2);

      // Both ports contend and re-request on each completion.
      auto_fn = 1'b1;
      rereq = 1'b1;
      tick(1'b0, 2'b11, 2'b11, 2'b00);
      idle(20);
      rereq = 1'b0;
      idle(10);

      // Protocol errors: free while idle, then a repeated drive on a pending port.
      auto_fn = 1'b0;
      do_reset();
      tick(1'b0, 2'b00, 2'b00, 2'b11);
      tick(1'b0, 2'b00, 2'b11, 2'b00);
      tick(1'b0, 2'b00, 2'b11, 2'b00);
      auto_fn = 1'b1;
      idle(8);

      // Re-drive on the port being freed, in the first busy cycle.
      auto_fn = 1'b0;
      do_reset();
      tick(1'b0, 2'b11, 2'b00, 2'b00);
      tick(1'b0, 2'b00, 2'b00, 2'b00);
      tick(1'b0, 2'b11, 2'b00, 2'b11);
      idle(2);
      tick(1'b0, 2'b00, 2'b00, 2'b11);
      idle(2);

      // Reset while busy, followed by a late downstream free.
      do_reset();
      tick(1'b0, 2'b11, 2'b00, 2'b00);
      idle(2);
      tick(1'b1, 2'b00, 2'b00, 2'b00);
      tick(1'b0, 2'b00, 2'b00, 2'b11);
      idle(2);

      // Sixteen completions wrap the 4-bit counter.
      do_reset();
      for (int k = 0; k < 16; k++) begin
         tick(1'b0, 2'b00, 2'b11, 2'b00);
         tick(1'b0, 2'b00, 2'b00, 2'b00);
         tick(1'b0, 2'b00, 2'b00, 2'b11);
         tick(1'b0, 2'b00, 2'b00, 2'b00);
      end
      idle(2);

      // Random legal traffic with a reactive downstream.
      do_reset();
      auto_fn = 1'b1;
      rnd_mode = 1;
      idle(600);

      // Random traffic including protocol errors and occasional resets.
      rnd_mode = 2;
      for (int k = 0; k < 400; k++) begin
         tick($urandom_range(0, 99) == 0, 2'b00, 2'b00, 2'b00);
      end

      // Drain and make sure nothing expected is left outstanding.
      rnd_mode = 0;
      idle(10);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("grants_left", i, qg[i].size(), 0);
         chk("frees_left", i, qf[i].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
